// File: rtl/instr_packer.sv
// instr_packer: encodes decoded I/S/B instruction fields into RV32I words and
// streams them into instruction memory through a 2-entry FIFO with backpressure.
// Optional feature: define INSTR_PACKER_RANGE_CHECK_EN to reject immediates that
// do not fit their encoding (and odd branch offsets); otherwise bits are truncated.
module instr_packer #(
   parameter int ADDR_W    = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [ADDR_W-1:0]    num_instr,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           in_opcode,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [2:0]           in_funct3,
   input  logic [31:0]          in_imm,
   output logic                 mem_we,
   input  logic                 mem_wready,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [31:0]          mem_wdata,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [ADDR_W-1:0]    ADDR_ONE = 1;
   localparam logic [ERR_CNT_W-1:0] ERR_ONE  = 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      base_q;
   logic [ADDR_W-1:0]      num_q;
   logic [ADDR_W-1:0]      accepted_q;
   logic [ADDR_W-1:0]      written_q;
   logic [31:0]            fifo_q [2];
   logic                   rd_ptr_q;
   logic                   wr_ptr_q;
   logic [1:0]             count_q;
   logic                   err_q;
   logic [ERR_CNT_W-1:0]   err_cnt_q;

   logic                   accept;
   logic                   push;
   logic                   pop;
   logic                   reject;
   logic                   legal;
   logic [31:0]            word;
   logic                   imm12_ok;
   logic                   imm13_ok;
   logic                   start_load;

   // Upper immediate bits only matter to the range check; keep lint quiet otherwise.
   logic                   unused_imm;
   assign unused_imm = ^in_imm[31:13];

   // Immediate range qualification for 12-bit (I/S) and 13-bit (B) encodings.
`ifdef INSTR_PACKER_RANGE_CHECK_EN
   logic signed [31:0] imm_s;
   assign imm_s    = in_imm;
   assign imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
   assign imm13_ok = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
`else
   assign imm12_ok = 1'b1;
   assign imm13_ok = 1'b1;
`endif

   // Encode the incoming field set and decide whether it is legal.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      word  = 32'h0;
      legal = 1'b0;
      case (in_opcode)
         OP_LOAD: begin
            word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            legal = imm12_ok;
         end
         OP_STORE: begin
            word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            legal = imm12_ok;
         end
         OP_BRANCH: begin
            word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
            legal = imm13_ok;
         end
         default: begin
            word  = 32'h0;
            legal = 1'b0;
         end
      endcase
   end

   // Handshakes and outputs derived from registered state only.
   always_comb begin
      in_ready   = (state_q == S_RUN) && (count_q != 2'd2) && (accepted_q < num_q);
      accept     = in_valid && in_ready;
      push       = accept && legal;
      reject     = accept && !legal;
      mem_we     = (count_q != 2'd0);
      pop        = mem_we && mem_wready;
      mem_addr   = base_q + written_q;
      mem_wdata  = fifo_q[rd_ptr_q];
      busy       = (state_q == S_RUN);
      done       = (state_q == S_DONE);
      err        = err_q;
      err_cnt    = err_cnt_q;
      start_load = (state_q == S_IDLE) && start;
   end

   // Next-state logic for the load sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if ((accepted_q == num_q) && (count_q == 2'd0)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Load context, progress counters and error tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q     <= '0;
         num_q      <= '0;
         accepted_q <= '0;
         written_q  <= '0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else if (start_load) begin
         base_q     <= base_addr;
         num_q      <= num_instr;
         accepted_q <= '0;
         written_q  <= '0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         if (accept) accepted_q <= accepted_q + ADDR_ONE;
         if (pop)    written_q  <= written_q + ADDR_ONE;
         if (reject) begin
            err_q <= 1'b1;
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_ONE;
         end
      end
   end

   // Two-entry word FIFO; the head drives the memory write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the storage is reset because its head is visible on mem_wdata, which must read 0 after reset.
         fifo_q[0] <= 32'h0;
         fifo_q[1] <= 32'h0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= word;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule
